rr_arbiter_lock: RTL
====================

Name: rr_arbiter_lock

Overview:
- Parametrised N-way round-robin arbiter. Generalises the 4-bit rotating priority selector to any requester count.
- Priority rotates on actual grants (last winner drops to lowest priority) rather than on a free-running counter.
- Adds registered one-hot grant, encoded grant index, and bounded grant locking for multi-cycle transfers.
- Sits in front of shared resources (CDB, memory port, FU issue) where N requesters contend.

Parameters:
- N, 8, number of requesters; legal range 2 and above; non-power-of-two is legal.
- MAX_HOLD, 4, maximum consecutive cycles one requester may hold a locked grant; legal range 1 and above.
- IW, $clog2(N), width of index outputs; derived, not overridden.

Ports:
- CLK  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-low.
- en  input  1  arbitration enable.
- req  input  N  request per requester; requester holds req until granted.
- lock  input  N  per-requester request to keep the current grant next cycle.
- gnt  output  N  registered one-hot grant; all zero when idle.
- gnt_vld  output  1  equals |gnt.
- gnt_idx  output  IW  index of granted requester; 0 when gnt_vld=0.
- ptr  output  IW  current highest-priority index, for debug and verification.

Behaviour:
- All outputs are registered. Values present after edge t+1 are computed from req, lock, en at edge t plus internal state.
- Reset: sampled at a rising CLK edge with rst=0. Sets gnt=0, gnt_vld=0, gnt_idx=0, ptr=0, hold_cnt=0. Reset overrides everything, including mid-grant or mid-lock.
- Internal hold_cnt counts extra cycles the current grant has been held. Range 0..MAX_HOLD-1.
- Per edge, when rst=1 and en=1, decisions are evaluated in priority order:
  1. HOLD: gnt[i]=1 and req[i]=1 and lock[i]=1 and hold_cnt < MAX_HOLD-1. Result: gnt unchanged, hold_cnt+1, ptr unchanged.
  2. ARBITRATE: some req bit is set. Winner w is the first index with req=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1. Result: gnt=onehot(w), gnt_idx=w, ptr=(w+1) mod N, hold_cnt=0.
  3. IDLE: req is all zero. Result: gnt=0, gnt_idx=0, ptr unchanged, hold_cnt=0.
- When en=0, at the next edge: gnt=0, gnt_idx=0, hold_cnt=0, ptr unchanged.
- Lock expiry: once hold_cnt reaches MAX_HOLD-1, the holder re-arbitrates at lowest priority (ptr already points past it). If it is the only requester it is re-granted with hold_cnt=0. Expected consequence: a sole requester with lock stuck high sees a continuous grant.
- Holder dropping req or lock: takes the ARBITRATE path immediately; its lock is lost.
- lock on a non-granted requester has no effect.
- lock=1 with req=0 has no effect.
- ptr wrap: increment modulo N. For non-power-of-two N, ptr never exceeds N-1.
- Invariants:
  - gnt is one-hot or zero.
  - gnt[i] implies req[i] was 1 at the previous edge.
  - With all requests steady, each requester is granted within N·MAX_HOLD cycles (no starvation).
- No combinational path from any input to any output.

Test Plan (N=4, MAX_HOLD=3 unless noted):
1. Reset with active traffic:
   - Hold rst=0 for 2 cycles with req=4'b1111.
   - Required: gnt=0, gnt_vld=0, gnt_idx=0, ptr=0.
   - Release rst; first grant is 4'b0001 one cycle later.
2. Full rotation, no locks:
   - req=4'b1111, lock=0, en=1.
   - Required gnt sequence: 0001, 0010, 0100, 1000, 0001.
   - Required ptr sequence: 1, 2, 3, 0, 1.
   - gnt_idx tracks 0, 1, 2, 3, 0.
3. Sparse requests with wrap:
   - From ptr=0, req=4'b1010.
   - Required: gnt alternates 0010, 1000, 0010; ptr alternates 2, 0, 2.
   - Then req=0: gnt=0, gnt_vld=0, ptr holds at its last value.
4. Lock limit:
   - req=4'b1111, lock=4'b0001, ptr=0.
   - Required: gnt=0001 for exactly 3 consecutive cycles, then 0010, 0100, 1000, then 0001 for 3 cycles again.
5. Enable, lock release, and mid-lock reset:
   - (a) en=0 during a locked grant of requester 2: next cycle gnt=0, ptr stays 3. Re-enable with req=1111: gnt=1000.
   - (b) Holder drops lock after 1 hold cycle: the next grant goes to the next requester in rotation.
   - (c) rst=0 while gnt=0100 locked: next edge gnt=0, ptr=0.
6. Non-power-of-two (N=5, MAX_HOLD=1):
   - req=5'b11111, lock=5'b11111.
   - Required: gnt cycles 00001→00010→00100→01000→10000→00001; lock is ignored.
   - ptr wraps 4→0 and never reads 5–7.

Source files
------------

// File: rtl/rr_arbiter_lock.sv
// N-way round-robin arbiter: priority rotates past each winner, and a granted
// requester may lock its grant for up to MAX_HOLD consecutive cycles.
module rr_arbiter_lock #(
  parameter  int N        = 8,
  parameter  int MAX_HOLD = 4,
  localparam int IW       = $clog2(N)
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  lock,
  output logic [N-1:0]  gnt,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx,
  output logic [IW-1:0] ptr
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [N-1:0]  gnt_q, gnt_d;
  logic          gnt_vld_q, gnt_vld_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  logic [IW-1:0] cand_idx [N];
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic          hold_ok;

  // cand_idx[k] is the requester with k-th highest priority: (ptr + k) mod N
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [IW:0] sum;
    assign sum          = {1'b0, ptr_q} + (IW+1)'(gi);
    assign cand_idx[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!win_found && req[cand_idx[k]]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  assign hold_ok = (|(gnt_q & req & lock)) && (int'(hold_cnt_q) < MAX_HOLD - 1);

  always_comb begin
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    if (!en) begin
      gnt_d      = '0;
      gnt_idx_d  = '0;
      hold_cnt_d = '0;
    end else if (hold_ok) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
    end else if (win_found) begin
      gnt_d      = N'(1) << win_idx;
      gnt_idx_d  = win_idx;
      ptr_d      = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
      hold_cnt_d = '0;
    end else begin
      gnt_d      = '0;
      gnt_idx_d  = '0;
      hold_cnt_d = '0;
    end
    gnt_vld_d = |gnt_d;
  end

  always_ff @(posedge CLK) begin
    if (!rst) begin
      gnt_q      <= '0;
      gnt_vld_q  <= 1'b0;
      gnt_idx_q  <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      gnt_q      <= gnt_d;
      gnt_vld_q  <= gnt_vld_d;
      gnt_idx_q  <= gnt_idx_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = gnt_vld_q;
  assign gnt_idx = gnt_idx_q;
  assign ptr     = ptr_q;

endmodule
